st7735s_spi_rx: RTL and testbench

Receive-side counterpart of the ST7735S write link: passively samples the 4-wire serial bus (SCL, SDA, D/CX, CSX) in the system clock domain and reassembles transmitted bytes with their command/data flag. Used as a bus monitor in the display subsystem and as the display-side model for closed-loop checking of the LCD driver. Purely receive-only; never drives the bus.

---
 rtl/st7735s_spi_rx.sv | 165 ++++++++++++++++
 tb/tb_st7735s_spi_rx.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/st7735s_spi_rx.sv
// Passive receiver for the ST7735S 4-wire serial write link. It samples SCL/SDA/D/CX/CSX in the
// i_clk domain and rebuilds bytes with their D/CX flag. Define ST7735S_SPI_RX_CMD_TRACK_EN to enable command tracking.
module st7735s_spi_rx #(
  parameter int c_SYNC_STAGES = 2,
  parameter int c_PARAM_CNT_W = 4
) (
  input  logic                     i_clk,
  input  logic                     i_nrst,
  input  logic                     i_spi_clk,
  input  logic                     i_spi_mosi,
  input  logic                     i_spi_dc,
  input  logic                     i_spi_ss,
  output logic [7:0]               o_data,
  output logic                     o_ncommand,
  output logic                     o_data_valid,
  output logic                     o_frame_err,
  output logic                     o_busy,
  output logic [7:0]               o_last_cmd,
  output logic [c_PARAM_CNT_W-1:0] o_param_idx
);

  logic [c_SYNC_STAGES-1:0] scl_sync_q, sda_sync_q, dc_sync_q, ss_sync_q;
  logic                     scl_dly_q, ss_dly_q;
  logic                     scl_s, sda_s, dc_s, ss_s;
  logic                     scl_rise_s, ss_fall_s, ss_rise_s, scl_ok_s;

  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] sr_q, sr_d;
  logic [7:0] data_q, data_d;
  logic       ncmd_q, ncmd_d;
  logic       valid_q, valid_d;
  logic       ferr_q, ferr_d;
  logic       busy_q, busy_d;

  // Synchronizer chains and edge-detect delay flops; CSX idles high.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      scl_sync_q <= {c_SYNC_STAGES{1'b0}};
      sda_sync_q <= {c_SYNC_STAGES{1'b0}};
      dc_sync_q  <= {c_SYNC_STAGES{1'b0}};
      ss_sync_q  <= {c_SYNC_STAGES{1'b1}};
      scl_dly_q  <= 1'b0;
      ss_dly_q   <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[c_SYNC_STAGES-2:0], i_spi_clk};
      sda_sync_q <= {sda_sync_q[c_SYNC_STAGES-2:0], i_spi_mosi};
      dc_sync_q  <= {dc_sync_q[c_SYNC_STAGES-2:0], i_spi_dc};
      ss_sync_q  <= {ss_sync_q[c_SYNC_STAGES-2:0], i_spi_ss};
      scl_dly_q  <= scl_sync_q[c_SYNC_STAGES-1];
      ss_dly_q   <= ss_sync_q[c_SYNC_STAGES-1];
    end
  end

  assign scl_s      = scl_sync_q[c_SYNC_STAGES-1];
  assign sda_s      = sda_sync_q[c_SYNC_STAGES-1];
  assign dc_s       = dc_sync_q[c_SYNC_STAGES-1];
  assign ss_s       = ss_sync_q[c_SYNC_STAGES-1];
  assign scl_rise_s = scl_s & ~scl_dly_q;
  assign ss_fall_s  = ~ss_s & ss_dly_q;
  assign ss_rise_s  = ss_s & ~ss_dly_q;
  // In the CSX-rise cycle the bus still counts as selected, so a coincident 8th SCL rise completes its byte.
  assign scl_ok_s   = scl_rise_s & (~ss_s | ss_rise_s);

  // Bit assembly, byte completion and frame-error detection.
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    sr_d      = sr_q;
    data_d    = data_q;
    ncmd_d    = ncmd_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    busy_d    = ~ss_s;
    if (ss_fall_s) begin
      bit_cnt_d = 3'd0;
      sr_d      = 7'd0;
    end else if (scl_ok_s) begin
      sr_d      = {sr_q[5:0], sda_s};
      bit_cnt_d = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        data_d  = {sr_q, sda_s};
        ncmd_d  = dc_s;
        valid_d = 1'b1;
      end else begin
        valid_d = 1'b0;
      end
    end else begin
      bit_cnt_d = bit_cnt_q;
    end
    if (ss_rise_s) begin
      ferr_d    = (bit_cnt_d != 3'd0);
      bit_cnt_d = 3'd0;
      sr_d      = 7'd0;
    end else begin
      ferr_d    = 1'b0;
    end
  end

  // Receiver state and registered outputs.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      bit_cnt_q <= 3'd0;
      sr_q      <= 7'd0;
      data_q    <= 8'd0;
      ncmd_q    <= 1'b0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      sr_q      <= sr_d;
      data_q    <= data_d;
      ncmd_q    <= ncmd_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      busy_q    <= busy_d;
    end
  end

  assign o_data       = data_q;
  assign o_ncommand   = ncmd_q;
  assign o_data_valid = valid_q;
  assign o_frame_err  = ferr_q;
  assign o_busy       = busy_q;

`ifdef ST7735S_SPI_RX_CMD_TRACK_EN
  logic [7:0]               last_cmd_q, last_cmd_d;
  logic [c_PARAM_CNT_W-1:0] pidx_q, pidx_d;

  // Command tracking: a command resets the parameter index, data bytes advance it up to all-ones.
  always_comb begin
    last_cmd_d = last_cmd_q;
    pidx_d     = pidx_q;
    if (valid_d) begin
      if (!ncmd_d) begin
        last_cmd_d = data_d;
        pidx_d     = {c_PARAM_CNT_W{1'b0}};
      end else if (pidx_q != {c_PARAM_CNT_W{1'b1}}) begin
        pidx_d     = pidx_q + {{(c_PARAM_CNT_W-1){1'b0}}, 1'b1};
      end else begin
        pidx_d     = pidx_q;
      end
    end else begin
      last_cmd_d = last_cmd_q;
    end
  end

  // Command tracking registers.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      last_cmd_q <= 8'd0;
      pidx_q     <= {c_PARAM_CNT_W{1'b0}};
    end else begin
      last_cmd_q <= last_cmd_d;
      pidx_q     <= pidx_d;
    end
  end

  assign o_last_cmd  = last_cmd_q;
  assign o_param_idx = pidx_q;
`else
  assign o_last_cmd  = 8'd0;
  assign o_param_idx = {c_PARAM_CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_st7735s_spi_rx.sv
// Directed bench for st7735s_spi_rx: a bus driver pushes expected bytes to a scoreboard,
// a negedge monitor pops and compares them against every o_data_valid pulse.
module tb_st7735s_spi_rx;
  localparam int SYNC = 2;
  localparam int PW   = 4;

  logic          clk = 1'b0;
  logic          nrst, scl, sda, dc, ss;
  logic [7:0]    o_data, o_last_cmd;
  logic          o_ncommand, o_data_valid, o_frame_err, o_busy;
  logic [PW-1:0] o_param_idx;

  st7735s_spi_rx #(.c_SYNC_STAGES(SYNC), .c_PARAM_CNT_W(PW)) dut (
    .i_clk(clk), .i_nrst(nrst), .i_spi_clk(scl), .i_spi_mosi(sda), .i_spi_dc(dc), .i_spi_ss(ss),
    .o_data(o_data), .o_ncommand(o_ncommand), .o_data_valid(o_data_valid), .o_frame_err(o_frame_err),
    .o_busy(o_busy), .o_last_cmd(o_last_cmd), .o_param_idx(o_param_idx)
  );

  always #10 clk = ~clk;

  typedef struct packed {
    logic          dc;
    logic [7:0]    b;
    logic [7:0]    lc;
    logic [PW-1:0] pi;
  } exp_t;

  exp_t          sb[$];
  int            checks = 0, errors = 0;
  int            cyc = 0, last_rise_cyc = 0, valid_cnt = 0, ferr_cnt = 0;
  logic [7:0]    m_last = 8'd0;
  logic [PW-1:0] m_pidx = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor: every valid cycle must match the oldest scoreboard entry.
  always @(negedge clk) begin
    exp_t e;
    if (o_frame_err === 1'b1) ferr_cnt++;
    if (o_data_valid === 1'b1) begin
      valid_cnt++;
      check("sb_nonempty_on_valid", {31'd0, sb.size() != 0}, 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("data", {24'd0, o_data}, {24'd0, e.b});
        check("ncommand", {31'd0, o_ncommand}, {31'd0, e.dc});
        check("last_cmd", {24'd0, o_last_cmd}, {24'd0, e.lc});
        check("param_idx", {28'd0, o_param_idx}, {28'd0, e.pi});
        check("busy_at_valid", {31'd0, o_busy}, 32'd1);
        check("valid_latency", cyc - last_rise_cyc, SYNC + 1);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [7:0] b, input logic d);
    exp_t e;
    if (!d) begin
      m_last = b;
      m_pidx = '0;
    end else if (m_pidx != {PW{1'b1}}) begin
      m_pidx = m_pidx + 1'b1;
    end
    e.dc = d;
    e.b  = b;
`ifdef ST7735S_SPI_RX_CMD_TRACK_EN
    e.lc = m_last;
    e.pi = m_pidx;
`else
    e.lc = 8'd0;
    e.pi = '0;
`endif
    sb.push_back(e);
  endtask

  task automatic send_bits(input logic [7:0] b, input logic d, input int nbits, input int half);
    for (int i = 0; i < nbits; i++) begin
      sda = b[7-i];
      dc  = d;
      tick(half);
      scl = 1'b1;
      last_rise_cyc = cyc;
      tick(half);
      scl = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic d, input int half);
    push_exp(b, d);
    send_bits(b, d, 8, half);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_data"}, {24'd0, o_data}, 32'd0);
    check({tag, "_ncmd"}, {31'd0, o_ncommand}, 32'd0);
    check({tag, "_valid"}, {31'd0, o_data_valid}, 32'd0);
    check({tag, "_ferr"}, {31'd0, o_frame_err}, 32'd0);
    check({tag, "_busy"}, {31'd0, o_busy}, 32'd0);
    check({tag, "_last"}, {24'd0, o_last_cmd}, 32'd0);
    check({tag, "_pidx"}, {28'd0, o_param_idx}, 32'd0);
  endtask

  initial begin
    nrst = 1'b0; scl = 1'b0; sda = 1'b0; dc = 1'b0; ss = 1'b1;
    tick(3);
    check_all_zero("reset");
    nrst = 1'b1;
    tick(5);

    // Single command byte.
    ss = 1'b0;
    tick(5);
    check("busy_low_cs", {31'd0, o_busy}, 32'd1);
    send_byte(8'h2A, 1'b0, 10);
    tick(10);
    check("t1_valid_cnt", valid_cnt, 1);

    // Four parameter bytes in the same frame.
    send_byte(8'h00, 1'b1, 10);
    send_byte(8'h00, 1'b1, 10);
    send_byte(8'h00, 1'b1, 10);
    send_byte(8'h7F, 1'b1, 10);
    tick(10);
    check("t2_valid_cnt", valid_cnt, 5);

    // Partial byte then CSX release.
    send_bits(8'hB1, 1'b1, 5, 10);
    tick(4);
    ss = 1'b1;
    tick(10);
    check("t3_ferr_cnt", ferr_cnt, 1);
    check("t3_valid_cnt", valid_cnt, 5);
    check("t3_data_hold", {24'd0, o_data}, 32'h7F);
    check("t3_busy_idle", {31'd0, o_busy}, 32'd0);

    // Back-to-back bytes at minimum half-bit.
    ss = 1'b0;
    tick(5);
    send_byte(8'hA5, 1'b1, 3);
    send_byte(8'h5A, 1'b1, 3);
    tick(10);
    check("t4_valid_cnt", valid_cnt, 7);
    check("t4_data", {24'd0, o_data}, 32'h5A);
    ss = 1'b1;
    tick(10);
    check("t4_no_ferr", ferr_cnt, 1);

    // Reset in the middle of a byte.
    ss = 1'b0;
    tick(5);
    send_bits(8'hC3, 1'b1, 4, 5);
    nrst = 1'b0;
    tick(2);
    check_all_zero("midreset");
    m_last = 8'd0;
    m_pidx = '0;
    nrst = 1'b1;
    tick(5);
    send_byte(8'h3C, 1'b0, 5);
    tick(10);
    check("t5_valid_cnt", valid_cnt, 8);
    check("t5_data", {24'd0, o_data}, 32'h3C);
    check("t5_ferr_cnt", ferr_cnt, 1);

    // Parameter index saturation.
    send_byte(8'h2C, 1'b0, 3);
    for (int i = 0; i < 20; i++) send_byte(8'(i * 7 + 1), 1'b1, 3);
    tick(10);
    check("t6_valid_cnt", valid_cnt, 29);
`ifdef ST7735S_SPI_RX_CMD_TRACK_EN
    check("t6_pidx_sat", {28'd0, o_param_idx}, 32'd15);
    check("t6_last_cmd", {24'd0, o_last_cmd}, 32'h2C);
`else
    check("t6_pidx_off", {28'd0, o_param_idx}, 32'd0);
    check("t6_last_off", {24'd0, o_last_cmd}, 32'd0);
`endif
    ss = 1'b1;
    tick(10);

    // SCL activity while deselected must be ignored.
    for (int i = 0; i < 16; i++) begin
      sda = 1'($urandom_range(1, 0));
      tick(3);
      scl = 1'b1;
      tick(3);
      scl = 1'b0;
    end
    tick(10);
    check("t7_valid_cnt", valid_cnt, 29);
    check("t7_ferr_cnt", ferr_cnt, 1);
    check("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
